// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller for the 64-bit program counter.
// Runs the instruction-memory request/ack handshake, applies load-use stalls
// from decode and branch/trap redirects from execute. A redirect that arrives
// while a fetch is still outstanding is buffered until that fetch completes.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   pc_cur            current PC (PC register output)
//   pc_next/pc_stall  next PC value and hold control for the PC register
//   imem_req/addr/ack instruction-memory fetch handshake (addr = pc_cur)
//   hazard_stall      decode load-use stall (level)
//   br_taken/target   execute branch/jump redirect
//   trap/trap_vec     trap redirect, wins over br_taken
//   if_valid/if_flush IF/ID capture and kill controls
//   timeout           sticky memory-timeout error
module pc_sequencer #(
    parameter logic [63:0] RESET_VEC   = 64'd0,
    parameter int unsigned INSTR_BYTES = 4,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] pc_cur,
    output logic [63:0] pc_next,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic        hazard_stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        trap,
    input  logic [63:0] trap_vec,
    output logic        if_valid,
    output logic        if_flush,
    output logic        timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        ERROR = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [63:0]        pend_tgt_q, pend_tgt_d;
    logic               pend_trap_q, pend_trap_d;

    logic               redir;
    logic [63:0]        redir_tgt;
    logic               at_limit;
    logic [CNT_W-1:0]   wait_inc;

    // Redirect source selection: trap wins over branch.
    assign redir     = trap | br_taken;
    assign redir_tgt = trap ? trap_vec : br_target;
    // >= so a count bumped on the FETCH->DRAIN handoff still trips the limit.
    assign at_limit  = (wait_cnt_q >= CNT_W'(MAX_WAIT - 1));
    assign wait_inc  = wait_cnt_q + CNT_W'(1);
    assign imem_addr = pc_cur;

    // State and redirect-buffer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= BOOT;
            wait_cnt_q  <= '0;
            pend_tgt_q  <= '0;
            pend_trap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_trap_q <= pend_trap_d;
        end
    end

    // Next-state and combinational outputs.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pend_tgt_d  = pend_tgt_q;
        pend_trap_d = pend_trap_q;
        pc_next     = RESET_VEC;
        pc_stall    = 1'b1;
        imem_req    = 1'b0;
        if_valid    = 1'b0;
        if_flush    = 1'b0;
        timeout     = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                pc_next  = pc_cur;
                if (redir) begin
                    if_flush = 1'b1;
                    if (imem_ack) begin
                        pc_next    = redir_tgt;
                        pc_stall   = 1'b0;
                        wait_cnt_d = '0;
                    end else begin
                        // Fetch still outstanding: park the target until it drains.
                        pend_tgt_d  = redir_tgt;
                        pend_trap_d = trap;
                        wait_cnt_d  = wait_inc;
                        state_d     = DRAIN;
                    end
                end else if (imem_ack) begin
                    wait_cnt_d = '0;
                    if (!hazard_stall) begin
                        if_valid = 1'b1;
                        pc_stall = 1'b0;
                        pc_next  = pc_cur + 64'(INSTR_BYTES);
                    end
                end else if (at_limit) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                pc_next  = pc_cur;
                // A pending trap is never displaced by a later branch.
                if (trap) begin
                    pend_tgt_d  = trap_vec;
                    pend_trap_d = 1'b1;
                end else if (br_taken && !pend_trap_q) begin
                    pend_tgt_d = br_target;
                end
                if (imem_ack) begin
                    pc_next     = pend_tgt_d;
                    pc_stall    = 1'b0;
                    wait_cnt_d  = '0;
                    pend_trap_d = 1'b0;
                    state_d     = FETCH;
                end else if (at_limit) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            ERROR: begin
                timeout = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule
